// File: rtl/nes_multipad.sv
// nes_multipad: shared latch/pulse poller for up to eight NES/SNES pads.
// All pads are shifted in parallel. On the last cycle of each bit window
// every pad's synchronised data line is captured, inverted to active-high.
// Once per frame the button state is published with press/release strobes.
module nes_multipad #(
   parameter int NUM_PADS        = 2,
   parameter int BITS            = 8,
   parameter int LATCH_CYCLES    = 1200,
   parameter int HALF_BIT_CYCLES = 600,
   parameter int POLL_CYCLES     = 1666666
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [NUM_PADS-1:0]      pad_data,
   output logic                     pad_latch,
   output logic                     pad_pulse,
   output logic [NUM_PADS*BITS-1:0] btns,
   output logic [NUM_PADS*BITS-1:0] pressed,
   output logic [NUM_PADS*BITS-1:0] released,
   output logic                     valid,
   output logic                     overrun
);

   localparam int W    = NUM_PADS * BITS;
   localparam int TMAX = (LATCH_CYCLES > HALF_BIT_CYCLES) ? LATCH_CYCLES : HALF_BIT_CYCLES;
   localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);
   localparam int PW   = (POLL_CYCLES < 2) ? 1 : $clog2(POLL_CYCLES);
   localparam int BW   = $clog2(BITS) + 1;

   localparam logic [TW-1:0] LATCH_LAST = TW'(LATCH_CYCLES - 1);
   localparam logic [TW-1:0] HALF_LAST  = TW'(HALF_BIT_CYCLES - 1);
   localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYCLES - 1);
   localparam logic [BW-1:0] BIT_LAST   = BW'(BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LATCH,
      S_GAP,
      S_PHI,
      S_PLO,
      S_DONE
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [PW-1:0]     poll_cnt;
   logic              tick;
   logic [TW-1:0]     timer;
   logic [BW-1:0]     bit_idx;
   logic              sample;
   logic [NUM_PADS-1:0] sync0;
   logic [NUM_PADS-1:0] sync1;
   logic [W-1:0]      shreg;

   assign tick = (poll_cnt == POLL_LAST);

   // Free-running frame-rate counter; the wrap cycle is the poll tick.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset)      poll_cnt <= '0;
      else if (tick)  poll_cnt <= '0;
      else            poll_cnt <= poll_cnt + 1'b1;
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // Next-state logic and the per-bit sample strobe.
   // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
   always_comb begin
      state_next = state;
      sample     = 1'b0;
      case (state)
         S_IDLE:  if (tick && enable) state_next = S_LATCH;
         S_LATCH: if (timer == LATCH_LAST) state_next = S_GAP;
         S_GAP: begin
            if (timer == HALF_LAST) begin
               sample     = 1'b1;
               state_next = S_PHI;
            end
         end
         S_PHI:   if (timer == HALF_LAST) state_next = S_PLO;
         S_PLO: begin
            if (timer == HALF_LAST) begin
               sample     = 1'b1;
               state_next = (bit_idx == BIT_LAST) ? S_DONE : S_PHI;
            end
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Phase timer restarts on every state change; bit index advances per sample.
   always_ff @(posedge clk) begin
      if (reset || state_next != state) timer <= '0;
      else                              timer <= timer + 1'b1;
      if (reset || state == S_IDLE)     bit_idx <= '0;
      else if (sample)                  bit_idx <= bit_idx + 1'b1;
   end

   // Pad outputs decoded from the next state so they leave flops directly.
   always_ff @(posedge clk) begin
      if (reset) begin
         pad_latch <= 1'b0;
         pad_pulse <= 1'b0;
      end else begin
         pad_latch <= (state_next == S_LATCH);
         pad_pulse <= (state_next == S_PHI);
      end
   end

   // Two-flop synchroniser on each asynchronous pad data line.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync0 <= '1;
         sync1 <= '1;
      end else begin
         sync0 <= pad_data;
         sync1 <= sync0;
      end
   end

   // Capture inverted (active-high) samples at the current bit position.
   always_ff @(posedge clk) begin
      if (reset) begin
         shreg <= '0;
      end else if (sample) begin
         for (int p = 0; p < NUM_PADS; p++) begin
            for (int k = 0; k < BITS; k++) begin
               if (bit_idx == BW'(k)) shreg[p*BITS + k] <= ~sync1[p];
            end
         end
      end
   end

   // Publish the frame: button state, edge strobes and valid, all aligned.
   always_ff @(posedge clk) begin
      if (reset) begin
         btns     <= '0;
         pressed  <= '0;
         released <= '0;
         valid    <= 1'b0;
      end else if (state == S_DONE) begin
         btns     <= shreg;
         pressed  <= shreg & ~btns;
         released <= btns & ~shreg;
         valid    <= 1'b1;
      end else begin
         pressed  <= '0;
         released <= '0;
         valid    <= 1'b0;
      end
   end

   // Sticky flag: a poll tick landed while a frame was still running.
   always_ff @(posedge clk) begin
      if (reset)                          overrun <= 1'b0;
      else if (tick && state != S_IDLE)   overrun <= 1'b1;
   end

endmodule

// File: tb/tb_nes_multipad.sv
// Directed bench for nes_multipad: a main instance (POLL=64) and an overrun
// instance (POLL=30), each driven by behavioural shift-register pad models.
module tb_nes_multipad;

   localparam int NP = 2;
   localparam int NB = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic enable = 1'b1;
   logic [7:0] raw0 = 8'hFE;
   logic [7:0] raw1 = 8'h7F;

   // main instance
   logic [NP-1:0]    pad_data;
   logic             pad_latch, pad_pulse, valid, overrun;
   logic [NP*NB-1:0] btns, pressed, released;
   // overrun instance
   logic [NP-1:0]    ov_data;
   logic             ov_latch, ov_pulse, ov_valid, ov_overrun;
   logic [NP*NB-1:0] ov_btns, ov_pressed, ov_released;

   nes_multipad #(.NUM_PADS(NP), .BITS(NB), .LATCH_CYCLES(4), .HALF_BIT_CYCLES(2),
                  .POLL_CYCLES(64)) dut (
      .clk(clk), .reset(reset), .enable(enable), .pad_data(pad_data),
      .pad_latch(pad_latch), .pad_pulse(pad_pulse), .btns(btns),
      .pressed(pressed), .released(released), .valid(valid), .overrun(overrun));

   nes_multipad #(.NUM_PADS(NP), .BITS(NB), .LATCH_CYCLES(4), .HALF_BIT_CYCLES(2),
                  .POLL_CYCLES(30)) dut_ov (
      .clk(clk), .reset(reset), .enable(enable), .pad_data(ov_data),
      .pad_latch(ov_latch), .pad_pulse(ov_pulse), .btns(ov_btns),
      .pressed(ov_pressed), .released(ov_released), .valid(ov_valid), .overrun(ov_overrun));

   always #5 clk = ~clk;

   // Pad models: load raw on latch, shift toward bit 0 on pulse rising edge.
   logic [7:0] sr0 = 8'hFF, sr1 = 8'hFF, osr0 = 8'hFF, osr1 = 8'hFF;
   logic prev_p = 1'b0, prev_op = 1'b0;
   always @(posedge clk) begin
      prev_p  <= pad_pulse;
      prev_op <= ov_pulse;
      if (pad_latch) begin
         sr0 <= raw0; sr1 <= raw1;
      end else if (pad_pulse && !prev_p) begin
         sr0 <= {1'b1, sr0[7:1]}; sr1 <= {1'b1, sr1[7:1]};
      end
      if (ov_latch) begin
         osr0 <= raw0; osr1 <= raw1;
      end else if (ov_pulse && !prev_op) begin
         osr0 <= {1'b1, osr0[7:1]}; osr1 <= {1'b1, osr1[7:1]};
      end
   end
   assign pad_data = {sr1[0], sr0[0]};
   assign ov_data  = {osr1[0], osr0[0]};

   int n_tests = 0;
   int n_fail  = 0;
   int cyc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Per-window observations
   int lat_rise, lat_hi, pul_rise, pul_hi, val_cnt, val_cyc, stray;
   int ov_set, ov_vcnt, ov_vcyc;
   logic [15:0] v_btns, v_pr, v_rl, ov_vbtns;
   logic prev_lat, prev_pul;

   task automatic clear();
      lat_rise = -1; lat_hi = 0; pul_rise = 0; pul_hi = 0;
      val_cnt = 0; val_cyc = -1; stray = 0;
      ov_set = -1; ov_vcnt = 0; ov_vcyc = -1;
      v_btns = '0; v_pr = '0; v_rl = '0; ov_vbtns = '0;
      prev_lat = pad_latch; prev_pul = pad_pulse;
   endtask

   // Advance to cycle 'stop', sampling on each falling edge.
   task automatic run_to(input int stop);
      while (cyc < stop) begin
         @(negedge clk);
         cyc++;
         if (pad_latch && !prev_lat && lat_rise < 0) lat_rise = cyc;
         if (pad_latch) lat_hi++;
         if (pad_pulse && !prev_pul) pul_rise++;
         if (pad_pulse) pul_hi++;
         if (valid) begin
            val_cnt++; val_cyc = cyc; v_btns = btns; v_pr = pressed; v_rl = released;
         end else if (pressed != '0 || released != '0) begin
            stray++;
         end
         if (ov_overrun && ov_set < 0) ov_set = cyc;
         if (ov_valid) begin
            ov_vcnt++; ov_vcyc = cyc; ov_vbtns = ov_btns;
         end
         prev_lat = pad_latch;
         prev_pul = pad_pulse;
      end
   endtask

   initial begin
      cyc = 0;
      repeat (3) @(negedge clk);
      check("rst_latch",   pad_latch, 0);
      check("rst_pulse",   pad_pulse, 0);
      check("rst_btns",    btns, 0);
      check("rst_valid",   valid, 0);
      check("rst_overrun", overrun, 0);

      // Frame 1: timing and first button pattern
      reset = 1'b0;
      cyc = 0;
      clear();
      run_to(110);
      check("f1_latch_rise", lat_rise, 64);
      check("f1_latch_len",  lat_hi, 4);
      check("f1_pulses",     pul_rise, 7);
      check("f1_pulse_hi",   pul_hi, 14);
      check("f1_valid_cyc",  val_cyc, 99);
      check("f1_valid_cnt",  val_cnt, 1);
      check("f1_btns",       v_btns, 16'h8001);
      check("f1_pressed",    v_pr, 16'h8001);
      check("f1_released",   v_rl, 16'h0000);
      check("f1_stray",      stray, 0);
      check("ov_set_cyc",    ov_set, 60);
      check("ov_f1_cyc",     ov_vcyc, 65);
      check("ov_f1_btns",    ov_vbtns, 16'h8001);

      // Frame 2: pad0 A released, B pressed
      raw0 = 8'hFD;
      clear();
      run_to(190);
      check("f2_latch_rise", lat_rise, 128);
      check("f2_valid_cyc",  val_cyc, 163);
      check("f2_btns",       v_btns, 16'h8002);
      check("f2_pressed",    v_pr, 16'h0002);
      check("f2_released",   v_rl, 16'h0001);
      check("f2_stray",      stray, 0);
      check("main_overrun",  overrun, 0);
      check("ov_sticky",     ov_overrun, 1);
      check("ov_vcnt",       ov_vcnt, 2);
      check("ov_f3_cyc",     ov_vcyc, 185);
      check("ov_f3_btns",    ov_vbtns, 16'h8002);

      // Enable dropped during PHI of bit 3
      clear();
      run_to(206);
      check("f3_latch_rise", lat_rise, 192);
      check("f3_phi_b3",     pad_pulse, 1);
      enable = 1'b0;
      clear();
      run_to(330);
      check("dis_latches",   lat_hi, 0);
      check("dis_valid_cnt", val_cnt, 1);
      check("dis_valid_cyc", val_cyc, 227);
      check("dis_btns",      v_btns, 16'h8002);
      check("dis_pressed",   v_pr, 16'h0000);
      enable = 1'b1;
      clear();
      run_to(385);
      check("reen_latch",    lat_rise, 384);

      // One-cycle reset during LATCH
      check("pre_rst_latch", pad_latch, 1);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_latch",    pad_latch, 0);
      check("mid_rst_btns",     btns, 0);
      check("mid_rst_pressed",  pressed, 0);
      check("mid_rst_released", released, 0);
      check("mid_rst_valid",    valid, 0);
      reset = 1'b0;
      cyc = 0;
      clear();
      run_to(70);
      check("post_rst_latch", lat_rise, 64);
      check("post_rst_stray", stray, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/nes_multipad.md
# nes_multipad

Parametrised serial game-pad poller that services up to N NES/SNES-style controllers from one shared latch/pulse pair and N serial data lines. It generates the controller protocol timing and samples every data line in parallel. Each frame it publishes active-high button vectors together with one-cycle press/release strobes and a frame-valid pulse. It replaces per-controller poller instances in the top level and feeds game logic and LED debug displays directly.

## Interface
- `NUM_PADS`, 2: number of controllers (1–8).
- `BITS`, 8: bits shifted per controller per frame; 8 for NES, 16 for SNES.
- `LATCH_CYCLES`, 1200: latch high time in clk cycles (12 µs at 100 MHz).
- `HALF_BIT_CYCLES`, 600: half period of the pulse clock in clk cycles (6 µs).
- `POLL_CYCLES`, 1666666: frame start period in clk cycles (60 Hz). Must exceed FRAME_LEN (defined below).
- `clk`  in  1  system clock, 100 MHz.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  when high, frames start on poll ticks.
- `pad_data`  in  NUM_PADS  serial data, one bit per pad; active-low (0 = pressed).
- `pad_latch`  out  1  shared latch to all pads.
- `pad_pulse`  out  1  shared shift clock to all pads.
- `btns`  out  NUM_PADS*BITS  button state, active-high. Pad p bit k is at index p*BITS+k; k=0 is the first bit shifted (A).
- `pressed`  out  NUM_PADS*BITS  one-cycle strobe per button on a 0→1 transition.
- `released`  out  NUM_PADS*BITS  one-cycle strobe per button on a 1→0 transition.
- `valid`  out  1  one-cycle pulse when `btns` has been updated.
- `overrun`  out  1  sticky; set when a poll tick arrives while a frame is in progress.

## Operation
- Poll counter: free-running, counts 0..POLL_CYCLES-1 and wraps. The wrap cycle is the tick. The counter runs regardless of `enable`.
- FSM states and transitions:
  - IDLE: on tick with `enable`=1, go to LATCH.
  - LATCH: `pad_latch`=1 for LATCH_CYCLES.
  - GAP: latch and pulse low for HALF_BIT_CYCLES. On the last cycle, sample bit 0 of all pads.
  - PHI: `pad_pulse`=1 for HALF_BIT_CYCLES.
  - PLO: pulse low for HALF_BIT_CYCLES. On the last cycle, sample bit k.
  - PHI/PLO repeat for k=1..BITS-1.
  - DONE: 1 cycle, then IDLE.
- Sampling: `pad_data` is passed through a 2-flop synchroniser per pad; samples are taken from the synchronised value. Each sample bit is inverted (active-high) and written into a per-pad shift register at index k.
- DONE cycle:
  - `btns` <= shift register contents.
  - `pressed` = new & ~old; `released` = old & ~new.
  - `valid`=1.
  - All three are registered, so they appear together one cycle after DONE.
- `enable` deasserted mid-frame: the current frame completes normally and no further frames start. Re-asserting `enable` starts a frame at the next tick, not immediately.
- Tick while not IDLE: the tick is ignored and `overrun` is set to 1. `overrun` clears only on `reset`.
- Pad unplugged (data reads 1 with board pull-up): reported as no buttons pressed. No special handling.

## Timing
- Reset values: `pad_latch`=0, `pad_pulse`=0, `btns`=0, `pressed`=0, `released`=0, `valid`=0, `overrun`=0, FSM=IDLE, poll counter=0, shift registers=0.
- Reset mid-frame: on the next edge, latch and pulse drop to 0, the FSM returns to IDLE, and `btns` clears. No `released` strobes are generated for buttons cleared by reset.
- First frame: `pad_latch` rises on the clk edge POLL_CYCLES cycles after `reset` deasserts, given `enable`=1.
- FRAME_LEN = LATCH_CYCLES + HALF_BIT_CYCLES*(2*BITS-1) + 1 cycles, measured from latch rise to DONE. The default is 10201.
- `valid` is asserted FRAME_LEN cycles after `pad_latch` rises.
- Pulse count per frame: exactly BITS-1 pulses.
- Outputs are glitch-free: `pad_latch` and `pad_pulse` come straight from flops.
- Input-to-`btns` latency: data must be stable at least 2 cycles (the synchroniser depth) before the sample point.

## Test plan
Bench parameters for all scenarios: NUM_PADS=2, BITS=8, LATCH_CYCLES=4, HALF_BIT_CYCLES=2, POLL_CYCLES=64, so FRAME_LEN=35.

1. Reset release with `enable`=1:
   - `pad_latch` rises at cycle 64 and is high for 4 cycles.
   - 7 pulses follow, each 2 cycles high and 2 cycles low.
   - `valid` occurs at cycle 99.
2. Pad models shift raw 0xFE on pad0 and 0x7F on pad1 (active-low):
   - `btns`=0x8001 (pad0 bit 0, pad1 bit 7).
   - `pressed`=0x8001, `released`=0, both for 1 cycle.
3. Next frame with pad0 raw 0xFD, pad1 unchanged:
   - `btns`=0x8002.
   - `pressed`=0x0002, `released`=0x0001.
4. Deassert `enable` during PHI of bit 3:
   - The frame completes and `valid` pulses once.
   - No `pad_latch` occurs at the next two ticks.
   - Re-assert `enable`: the latch rises at the following tick.
5. Bench with POLL_CYCLES=30 (less than FRAME_LEN):
   - `overrun` reaches 1 at the first tick during a frame and stays 1.
   - Frames still complete with correct data.
6. Assert `reset` for 1 cycle during the LATCH state:
   - Next cycle: `pad_latch`=0, `btns`=0, no strobes.
   - The next latch comes 64 cycles after reset deasserts.
